// File: rtl/dd_capture_pkg.sv
// Shared types and constants for the ADC capture gate.
package dd_capture_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam logic [DATA_WIDTH_DEF-1:0] RAMP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/adc_capture_gate_sync_bit.sv
// Single-bit multi-flop synchroniser, async active-low reset to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc_capture_gate.sv
// ADC-domain capture gate feeding the dual-clock FIFO write port: arm/run FSM,
// ramp test pattern and saturating dropped-sample accounting.
module adc_capture_gate
  import dd_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int ARM_CYCLES  = 4,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] adcData,
  input  logic                  captureEnable,
  input  logic                  testMode,
  input  logic                  fifoFull,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outWrite,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] dropCount,
  output logic                  capturing
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

  logic cap_en_s;
  logic test_s;

  cap_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] adc_reg_q, adc_reg_d;
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_write_q, out_write_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  mode_q, mode_d;
  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [DATA_WIDTH-1:0] sample;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cap (
    .clock (clock),
    .nReset(nReset),
    .d     (captureEnable),
    .q     (cap_en_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_test (
    .clock (clock),
    .nReset(nReset),
    .d     (testMode),
    .q     (test_s)
  );

  always_comb begin
    state_d     = state_q;
    adc_reg_d   = adcData;
    ramp_d      = ramp_q;
    out_data_d  = out_data_q;
    out_write_d = 1'b0;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    mode_d      = mode_q;
    arm_cnt_d   = arm_cnt_q;
    sample      = mode_q ? ramp_q : adc_reg_q;

    case (state_q)
      IDLE: begin
        if (cap_en_s) begin
          state_d    = ARM;
          mode_d     = test_s;
          overflow_d = 1'b0;
          drop_d     = '0;
          ramp_d     = '0;
          arm_cnt_d  = '0;
        end
      end
      ARM: begin
        // Losing the request wins over completing the flush.
        if (!cap_en_s) begin
          state_d = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
          if (arm_cnt_q == ARM_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Ramp advances on every RUN cycle so FIFO-full gaps show up in the pattern.
        ramp_d = ramp_q + 1'b1;
        if (!cap_en_s) begin
          state_d = IDLE;
        end else if (fifoFull) begin
          overflow_d = 1'b1;
          if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end else begin
          out_write_d = 1'b1;
          out_data_d  = sample;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      adc_reg_q   <= '0;
      ramp_q      <= '0;
      out_data_q  <= '0;
      out_write_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      mode_q      <= 1'b0;
      arm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      adc_reg_q   <= adc_reg_d;
      ramp_q      <= ramp_d;
      out_data_q  <= out_data_d;
      out_write_q <= out_write_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      mode_q      <= mode_d;
      arm_cnt_q   <= arm_cnt_d;
    end
  end

  assign outData   = out_data_q;
  assign outWrite  = out_write_q;
  assign overflow  = overflow_q;
  assign dropCount = drop_q;
  assign capturing = (state_q == RUN);

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate with a cycle-level behavioural model and
// hand-computed literal expectations.
module tb_adc_capture_gate;
  import dd_capture_pkg::*;

  localparam int DW  = 10;
  localparam int SS  = 2;
  localparam int AC  = 4;
  localparam int DRW = 16;
  localparam logic [31:0] DROP_MAX = (32'd1 << DRW) - 32'd1;
  localparam logic [31:0] RAMP_MOD = 32'd1 << DW;

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic [DW-1:0] adcData = '0;
  logic          captureEnable = 1'b0;
  logic          testMode = 1'b0;
  logic          fifoFull = 1'b0;
  logic [DW-1:0] outData;
  logic          outWrite;
  logic          overflow;
  logic [DRW-1:0] dropCount;
  logic          capturing;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  adc_capture_gate #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .ARM_CYCLES (AC),
    .DROP_WIDTH (DRW)
  ) dut (
    .clock        (clock),
    .nReset       (nReset),
    .adcData      (adcData),
    .captureEnable(captureEnable),
    .testMode     (testMode),
    .fifoFull     (fifoFull),
    .outData      (outData),
    .outWrite     (outWrite),
    .overflow     (overflow),
    .dropCount    (dropCount),
    .capturing    (capturing)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: synchronisers are plain delay lines of the raw inputs,
  // arming is a countdown of flush cycles, and running tracks writes/drops.
  logic [SS-1:0] m_cap_sh, m_tst_sh;
  logic [31:0]   m_adc, m_ramp, m_data, m_drops, m_arm_left;
  bit            m_running, m_mode, m_wr, m_ovf;

  always @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      m_cap_sh <= '0; m_tst_sh <= '0; m_adc <= 0; m_ramp <= 0; m_data <= 0;
      m_drops <= 0; m_arm_left <= 0; m_running <= 0; m_mode <= 0; m_wr <= 0; m_ovf <= 0;
    end else begin
      m_cap_sh <= {m_cap_sh[SS-2:0], captureEnable};
      m_tst_sh <= {m_tst_sh[SS-2:0], testMode};
      m_adc    <= 32'(adcData);
      m_wr     <= 1'b0;
      if (m_running) begin
        m_ramp <= (m_ramp + 1) % RAMP_MOD;
        if (!m_cap_sh[SS-1]) begin
          m_running <= 1'b0;
        end else if (fifoFull) begin
          m_ovf <= 1'b1;
          if (m_drops < DROP_MAX) m_drops <= m_drops + 1;
        end else begin
          m_wr   <= 1'b1;
          m_data <= m_mode ? m_ramp : m_adc;
        end
      end else if (m_arm_left != 0) begin
        if (!m_cap_sh[SS-1]) m_arm_left <= 0;
        else if (m_arm_left == 1) begin
          m_arm_left <= 0;
          m_running  <= 1'b1;
        end else m_arm_left <= m_arm_left - 1;
      end else if (m_cap_sh[SS-1]) begin
        m_arm_left <= AC;
        m_mode     <= m_tst_sh[SS-1];
        m_ovf      <= 1'b0;
        m_drops    <= 0;
        m_ramp     <= 0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (cmp_en && nReset) begin
      check("m_outWrite", 32'(outWrite), 32'(m_wr));
      check("m_outData", 32'(outData), m_data);
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_dropCount", 32'(dropCount), m_drops);
      check("m_capturing", 32'(capturing), 32'(m_running));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) for the next posedge with outWrite high; returns edges waited.
  task automatic wait_write(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!outWrite && n <= limit);
  endtask

  int n;
  int bad;
  bit seen_wrap;
  logic [31:0] last, prev;

  initial begin
    // Reset state
    tick(3);
    check("rst_outData", 32'(outData), 0);
    check("rst_outWrite", 32'(outWrite), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_dropCount", 32'(dropCount), 0);
    check("rst_capturing", 32'(capturing), 0);
    nReset = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // 1: ADC pass-through. The first edge after the drive samples the request;
    // SS+AC+1 further edges later the first write is registered.
    adcData = 10'h155;
    captureEnable = 1'b1;
    wait_write(40, n);
    check("first_write_latency", n, SS + AC + 2);
    check("first_write_data", 32'(outData), 32'h155);
    check("first_write_capturing", 32'(capturing), 1);
    @(negedge clock); adcData = 10'h2AA;
    @(negedge clock); adcData = 10'h001;
    @(negedge clock); adcData = 10'h0AB;
    @(posedge clock); @(posedge clock); #1;
    check("adc_two_clock_latency", 32'(outData), 32'h0AB);
    @(negedge clock); captureEnable = 1'b0;
    tick(6);
    check("idle_after_disable", 32'(capturing), 0);

    // 2: ramp pattern with wrap
    testMode = 1'b1;
    tick(4);
    captureEnable = 1'b1;
    wait_write(40, n);
    check("ramp_first", 32'(outData), 0);
    prev = 32'(outData);
    bad = 0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      @(posedge clock); #1;
      if (!outWrite || 32'(outData) != (prev + 1) % RAMP_MOD) bad++;
      if (prev == 32'(RAMP_MAX) && outData == '0) seen_wrap = 1'b1;
      prev = 32'(outData);
    end
    check("ramp_step_errors", bad, 0);
    check("ramp_wrap_seen", 32'(seen_wrap), 1);

    // 3: three dropped cycles leave a gap of three ramp values
    @(posedge clock); #1;
    last = 32'(outData);
    @(negedge clock); fifoFull = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (outWrite) bad++;
    end
    @(negedge clock); fifoFull = 1'b0;
    @(posedge clock); #1;
    check("drop_no_writes", bad, 0);
    check("drop_resume_write", 32'(outWrite), 1);
    check("drop_resume_value", 32'(outData), (last + 4) % RAMP_MOD);
    check("drop_count_3", 32'(dropCount), 3);
    check("drop_overflow", 32'(overflow), 1);
    @(negedge clock); captureEnable = 1'b0;
    tick(6);
    check("idle_holds_overflow", 32'(overflow), 1);
    check("idle_holds_dropCount", 32'(dropCount), 3);
    captureEnable = 1'b1;
    tick(4);
    check("rearm_clears_overflow", 32'(overflow), 0);
    check("rearm_clears_dropCount", 32'(dropCount), 0);

    // 4: saturation of the drop counter
    tick(10);
    fifoFull = 1'b1;
    tick(65540);
    check("drop_saturated", 32'(dropCount), 32'hFFFF);
    check("drop_sat_overflow", 32'(overflow), 1);
    fifoFull = 1'b0;
    captureEnable = 1'b0;
    tick(6);

    // 5a: request withdrawn during ARM (lands on the would-be exit edge)
    testMode = 1'b0;
    captureEnable = 1'b1;
    tick(4);
    captureEnable = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (outWrite || capturing) bad++;
    end
    check("arm_abort_no_writes", bad, 0);

    // 5b: testMode toggled mid-RUN does not change the pattern
    @(negedge clock); testMode = 1'b1;
    tick(4);
    captureEnable = 1'b1;
    tick(12);
    testMode = 1'b0;
    adcData = 10'h155;
    @(posedge clock); #1;
    prev = 32'(outData);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (32'(outData) != (prev + 1) % RAMP_MOD) bad++;
      prev = 32'(outData);
    end
    check("mode_change_ignored", bad, 0);

    // 6: async reset mid-RUN
    @(negedge clock);
    check("pre_reset_write", 32'(outWrite), 1);
    #2 nReset = 1'b0;
    #1;
    check("async_rst_outWrite", 32'(outWrite), 0);
    check("async_rst_outData", 32'(outData), 0);
    check("async_rst_capturing", 32'(capturing), 0);
    check("async_rst_dropCount", 32'(dropCount), 0);
    tick(2);
    nReset = 1'b1;
    tick(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
